// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Bundles the writeback requester handshake and the register-file write port.
//
//   req_valid  [NREQ]     requester i has a write pending
//   req_rd     [5*NREQ]   destination register of requester i, bits [5i+4:5i]
//   req_data   [32*NREQ]  write data of requester i, bits [32i+31:32i]
//   req_ready  [NREQ]     one-hot or zero; requester i accepted this cycle
//   wr                    register-file write enable
//   rd         [5]        register-file destination address
//   write_data [32]       register-file write data
//
// Modports:
//   slave  - the arbiter (consumes requests, drives the write port)
//   master - the environment (drives requests, observes the write port)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr;
  logic [4:0]         rd;
  logic [31:0]        write_data;

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready,
    output wr,
    output rd,
    output write_data
  );

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready,
    input  wr,
    input  rd,
    input  write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single write port of the 32x32 register file between NREQ
// writeback requesters. Round-robin arbitration picks one requester per cycle;
// the winner is captured into a one-entry output stage that drives the
// register-file write port during the following cycle. A per-register pending
// bitmap reports which register is currently sitting in the stage.
//
// Ports:
//   clk        rising-edge clock, shared with the register file
//   rst_n      asynchronous active-low reset
//   freeze     blocks new grants, holds the stage and suppresses wr
//   bus        requester handshake + register-file write port (slave side)
//   pending    bit r set while a write to r sits in the output stage
//   grant_idx  index of the last granted requester (the round-robin pointer)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       freeze,
  regfile_wb_arbiter_if.slave        bus,
  output logic [31:0]                pending,
  output logic [2:0]                 grant_idx
);

  // Requester fields widened to 8 entries so a 3-bit index is always legal.
  logic [7:0]  valid_pad;
  logic [4:0]  rd_arr   [8];
  logic [31:0] data_arr [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NREQ) begin : g_live
        assign valid_pad[gi] = bus.req_valid[gi];
        assign rd_arr[gi]    = bus.req_rd[5*gi +: 5];
        assign data_arr[gi]  = bus.req_data[32*gi +: 32];
      end else begin : g_pad
        assign valid_pad[gi] = 1'b0;
        assign rd_arr[gi]    = 5'd0;
        assign data_arr[gi]  = 32'd0;
      end
    end
  endgenerate

  logic [2:0]  ptr_reg;
  logic        stage_valid_reg;
  logic [4:0]  stage_rd_reg;
  logic [31:0] stage_data_reg;

  logic        found;
  logic [2:0]  sel;
  logic        grant;

  // Round-robin search starting one past the pointer. ptr < NREQ <= 8 and the
  // offset is at most NREQ, so the 4-bit sum never overflows and a single
  // conditional subtract implements the modulo.
  always_comb begin
    logic [3:0] cand;
    found = 1'b0;
    sel   = ptr_reg;
    cand  = 4'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_reg} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!found && valid_pad[cand[2:0]]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end
    end
  end

  // rst_n gates the grant combinationally so req_ready stays low for the whole
  // reset interval, not just after the next clock edge.
  assign grant = found & ~freeze & rst_n;

  logic [NREQ-1:0] ready_vec;
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign ready_vec[gi] = grant && (sel == 3'(gi));
    end
  endgenerate
  assign bus.req_ready = ready_vec;

  // A grant cannot coincide with freeze, so the freeze branch only has to
  // hold the stage; without freeze and without a grant the stage drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg         <= 3'(NREQ - 1);
      stage_valid_reg <= 1'b0;
      stage_rd_reg    <= 5'd0;
      stage_data_reg  <= 32'd0;
    end else if (grant) begin
      ptr_reg         <= sel;
      stage_valid_reg <= 1'b1;
      stage_rd_reg    <= rd_arr[sel];
      stage_data_reg  <= data_arr[sel];
    end else if (!freeze) begin
      stage_valid_reg <= 1'b0;
    end
  end

  // Register 0 is hard-wired in the register file: an rd=0 entry occupies the
  // stage (so it rotates the pointer) but never writes or shows as pending.
  assign bus.wr         = stage_valid_reg & ~freeze & (stage_rd_reg != 5'd0);
  assign bus.rd         = stage_rd_reg;
  assign bus.write_data = stage_data_reg;
  assign pending        = stage_valid_reg ? ((32'd1 << stage_rd_reg) & ~32'd1) : 32'd0;
  assign grant_idx      = ptr_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32x32 register file. Shares the register file's single write port (`wr`, `rd`, `write_data`) between NREQ writeback requesters (ALU, load unit, multiplier, ...) using round-robin arbitration with a one-entry registered output stage. It sits between the execute/memory writeback sources and the register file. It also exports a per-register pending bitmap for hazard logic.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- clk  in  1  rising-edge clock, shared with the register file
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_rd  in  5*NREQ  destination register of requester i, at bits [5i+4:5i]
- req_data  in  32*NREQ  write data of requester i, at bits [32i+31:32i]
- req_ready  out  NREQ  one-hot or zero; requester i's write accepted this cycle
- freeze  in  1  debug/stall hold; blocks new grants and suppresses `wr`
- wr  out  1  register-file write enable
- rd  out  5  register-file destination address
- write_data  out  32  register-file write data
- pending  out  32  bit r set while a write to r sits in the output stage
- grant_idx  out  3  index of the last granted requester (observability)

## Operation
- **Handshake.** A transfer happens on a rising edge where `req_valid[i] & req_ready[i]`. Requester i holds `rd`/`data` stable until that edge. `req_ready` is combinational from `req_valid`, the pointer and `freeze`.
- **Arbitration.** Round-robin over requesters with `req_valid` high. The search starts at `(ptr+1) mod NREQ` and the first valid requester wins.
  - At most one `req_ready` bit is high per cycle.
  - No grant is made while `freeze=1`.
- **Pointer.** `ptr` updates to the granted index on each grant and holds otherwise. Reset value is NREQ-1, so requester 0 has first priority.
- **Output stage.** Holds `{stage_valid, stage_rd, stage_data}` and loads on a grant.
  - `stage_valid` clears when no grant occurs and `freeze=0`.
  - While `freeze=1`, stage contents and `stage_valid` hold.
- **Outputs.**
  - `wr = stage_valid & ~freeze & (stage_rd != 0)`.
  - `rd = stage_rd`, `write_data = stage_data`.
- **Register 0.**
  - A request with `rd=0` is granted normally. It rotates the pointer and occupies the stage for one cycle.
  - It never asserts `wr` and never sets `pending`.
- **Pending bitmap.** `pending = stage_valid ? (1 << stage_rd) & ~1 : 0`. Bit 0 is always 0.
- **Same rd, same cycle.** Only the winner is granted; the loser writes on a later cycle. Register-file write order equals grant order.
- **grant_idx** equals `ptr`.

## Timing
- **Reset (rst_n low, async).** All of the following clear immediately:
  - `stage_valid`, `stage_rd`, `stage_data`
  - `wr`, `rd`, `write_data`, `pending`
  - `ptr`/`grant_idx` reset to NREQ-1.
  - `req_ready` is 0 throughout reset.
- **Reset deassert.** Arbitration is live in the first cycle after `rst_n` rises.
- **Latency.** A grant at edge N gives `wr`/`rd`/`write_data` valid during cycle N+1. The register file captures the write at edge N+1, so total latency is 1 cycle from acceptance to `wr`.
- **Throughput.** One write per cycle, back-to-back, with no bubbles when any request is valid and `freeze=0`.
- **Freeze asserted with the stage valid.**
  - `wr` drops in the same cycle (combinational); stage contents hold.
  - On release, `wr` reasserts with the held entry in the first unfrozen cycle, and a new grant may load in that same edge.
- **Reset mid-operation.** An in-flight stage entry is discarded (not written). Requesters must re-present it.

## Test plan
- **Single write.** After reset, `req_valid=001`, rd=5, data=0x0000_00AA. Expect `req_ready=001` in cycle 0; `wr=1`, rd=5, `write_data=0xAA`, `pending=0x20` in cycle 1; `wr=0` in cycle 2.
- **Round robin.** All three valid continuously with distinct rd 1/2/3. Grants go 0,1,2,0,1,2. `wr` stays high every cycle from cycle 1 on, and `grant_idx` follows the grant.
- **rd=0 drop.** Requester 1 writes rd=0, data=0xDEAD. Expect `req_ready[1]` for one cycle and the pointer at 1. `wr` stays 0 and `pending` stays 0.
- **Freeze.** Grant rd=7 data=0x55, then hold `freeze=1` for 3 cycles. `wr=0` with rd=7 and data=0x55 held, `pending[7]=1`, and `req_ready=0`. After release, `wr=1` for rd=7 for one cycle.
- **Same rd.** Requesters 0 and 2 both target rd=9 (data 0x1 and 0x2) after reset. The register-file write sequence is 0x1 then 0x2 on consecutive cycles.
- **Async reset.** Drop `rst_n` mid-cycle while the stage holds rd=4. `wr`, `pending` and `rd` go to 0 before the next clock edge, and `grant_idx=NREQ-1`.
